tap_serializer: RTL and testbench
=================================

# tap_serializer

Parallel-in, serial-out companion to the four-tap left shift buffer. Accepts a four-word window (d0 oldest … d3 newest) in one handshake and emits it one signed word per beat, oldest first. Feeding its output beats into a left shift buffer for four clocks reproduces the original window on out_d0..out_d3. Used to stream cached activation windows between dilated convolution layers over a narrow valid/ready link.

## Interface
- W, default 16: signed element width.
- NUM_TAPS, default 4: words per window; fixed at 4 in this revision, elaboration error otherwise.
- clk  input  1  rising-edge clock.
- rst  input  1  reset rst, asynchronous, active-high; clock clk.
- in_valid  input  1  window on in_d0..in_d3 is valid.
- in_ready  output  1  block will capture the window this cycle.
- in_d0 … in_d3  input  W each, signed  window words, d0 oldest, d3 newest.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  W, signed  current beat.
- out_idx  output  2  tap index of current beat (0 = d0).
- out_last  output  1  high with the d3 beat (out_idx == 3).

## Operation
- Two states: IDLE (no window held) and SHIFT (window held, beats pending).
- Holding registers hold[0..3], index counter idx (2 bits).
- Load: in_valid & in_ready -> hold[i] <= in_di, idx <= 0, state <= SHIFT.
- Beat accept: out_valid & out_ready -> hold shifts left (hold[i] <= hold[i+1], hold[3] <= 0), idx <= idx+1.
- IDLE -> SHIFT on load. SHIFT -> IDLE on accepting beat idx==3 with no simultaneous load. SHIFT -> SHIFT (fresh window, idx <= 0) when beat idx==3 is accepted and a load occurs in the same cycle.
- in_ready = (state == IDLE) | (out_valid & out_ready & idx == 3). Combinational path out_ready -> in_ready is intended and documented for integrators.
- out_valid = (state == SHIFT); out_data = hold[0]; out_idx = idx; out_last = out_valid & (idx == 3).
- Data passes through unmodified: no arithmetic, no sign extension, no saturation; values such as -32768 and 32767 (W=16) reach out_data bit-exact.
- in_valid while in_ready low: window ignored, not captured; upstream holds it (standard valid/ready, valid must not drop before ready).
- out_valid, once high, stays high and out_data/out_idx stay stable until accepted.

## Timing
- Reset (async assert, sync release): state IDLE, hold[*] = 0, idx = 0; out_valid 0, out_data 0, out_idx 0, out_last 0, in_ready 1 after release.
- Reset mid-window: remaining beats discarded, no partial window emitted after release.
- Latency: window captured at edge k -> d0 beat on out_data in cycle after k.
- Throughput: one beat per clock with out_ready held high; back-to-back windows with no bubble (4 beats per window, sustained).
- Backpressure: out_ready low for any number of cycles stalls without loss or duplication.

## Structure
- Shared package cdcc_pkg: state typedef (IDLE, SHIFT), TAP_COUNT = 4 constant, default element width.
- Single flat module; no sub-module. Holding registers as array indexed 0..3 matching tap naming of the shift buffer.

## Test plan
- Reset then single window {d0..d3} = {1, -2, 3, -4}, out_ready=1 -> out_data 1,-2,3,-4 on four consecutive cycles starting cycle after load, out_idx 0..3, out_last only on -4, then out_valid 0, in_ready 1.
- Round trip: serializer output into left shift buffer, window {100,200,300,400} -> after four accepted beats shift buffer shows out_d0..out_d3 = 100,200,300,400.
- Backpressure: out_ready low for 3 cycles at idx 1 of {10,20,30,40} -> out_data held at 20, out_idx 1; resume -> 20,30,40 each once.
- Back-to-back: windows A={1,2,3,4}, B={5,6,7,8} with in_valid continuous, out_ready=1 -> eight contiguous beats 1..8, in_ready high only in IDLE and on the cycle beat 4 is accepted.
- Extremes: {-32768, 32767, 0, -1} -> identical bit patterns on out_data, out_last on -1.
- Async reset asserted mid-window after beat idx 1 -> outputs 0 immediately, no beats for rest of window after release, in_ready 1.

Source files
------------

// File: rtl/cdcc_pkg.sv
// Shared types and constants for the tap window serializer / shift buffer pair.
package cdcc_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int TAP_COUNT = 4;
    localparam int DEFAULT_W = 16;
endpackage

// File: rtl/tap_serializer.sv
// Parallel-in, serial-out window streamer: one four-word window in, one word per beat out, oldest first.
module tap_serializer
    import cdcc_pkg::*;
#(
    parameter int W        = DEFAULT_W,
    parameter int NUM_TAPS = TAP_COUNT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_d0,
    input  logic signed [W-1:0] in_d1,
    input  logic signed [W-1:0] in_d2,
    input  logic signed [W-1:0] in_d3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic [1:0]          out_idx,
    output logic                out_last
);

    if (NUM_TAPS != TAP_COUNT) begin : g_bad_num_taps
        $error("tap_serializer: NUM_TAPS must be 4");
    end

    state_t              state_q, state_d;
    logic signed [W-1:0] hold_q [0:3];
    logic signed [W-1:0] hold_d [0:3];
    logic [1:0]          idx_q, idx_d;

    logic beat_acc;
    logic last_acc;
    logic load;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        for (int i = 0; i < 4; i++) hold_d[i] = hold_q[i];

        out_valid = (state_q == SHIFT);
        out_data  = hold_q[0];
        out_idx   = idx_q;
        out_last  = out_valid && (idx_q == 2'd3);

        beat_acc  = out_valid && out_ready;
        last_acc  = beat_acc && (idx_q == 2'd3);
        // out_ready -> in_ready is combinational so a new window can land on the last beat's edge.
        in_ready  = (state_q == IDLE) || last_acc;
        load      = in_valid && in_ready;

        if (beat_acc) begin
            for (int i = 0; i < 3; i++) hold_d[i] = hold_q[i+1];
            hold_d[3] = '0;
            idx_d     = idx_q + 2'd1;
            if (last_acc) state_d = IDLE;
        end

        if (load) begin
            hold_d[0] = in_d0;
            hold_d[1] = in_d1;
            hold_d[2] = in_d2;
            hold_d[3] = in_d3;
            idx_d     = 2'd0;
            state_d   = SHIFT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            for (int i = 0; i < 4; i++) hold_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int i = 0; i < 4; i++) hold_q[i] <= hold_d[i];
        end
    end

endmodule

// File: tb/tb_tap_serializer.sv
// Directed bench for tap_serializer: single window, round trip, backpressure, back-to-back, extremes, async reset.
module tb_tap_serializer;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_d0 = '0, in_d1 = '0, in_d2 = '0, in_d3 = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] out_data;
    logic [1:0]          out_idx;
    logic                out_last;

    int total = 0;
    int bad   = 0;

    tap_serializer #(.W(W), .NUM_TAPS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_d0     (in_d0),
        .in_d1     (in_d1),
        .in_d2     (in_d2),
        .in_d3     (in_d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input logic signed [W-1:0] a, b, c, d);
        in_d0 = a; in_d1 = b; in_d2 = c; in_d3 = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_idx !== 2'd0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: got v=%b d=%0d i=%0d l=%b r=%b want 0 0 0 0 1",
                     out_valid, out_data, out_idx, out_last, in_ready);
        end
    endtask

    task automatic test_single();
        logic signed [W-1:0] exp [0:3];
        exp[0] = 16'sd1; exp[1] = -16'sd2; exp[2] = 16'sd3; exp[3] = -16'sd4;
        set_win(exp[0], exp[1], exp[2], exp[3]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_idx !== 2'(i) || out_last !== (i == 3)) begin
                bad++;
                $display("FAIL single beat%0d: got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d l=%b",
                         i, out_valid, out_data, out_idx, out_last, exp[i], i, (i == 3));
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL single idle: got v=%b r=%b l=%b want v=0 r=1 l=0", out_valid, in_ready, out_last);
        end
    endtask

    task automatic test_roundtrip();
        logic signed [W-1:0] sb  [0:3];
        logic signed [W-1:0] exp [0:3];
        int beats = 0;
        exp[0] = 16'sd100; exp[1] = 16'sd200; exp[2] = 16'sd300; exp[3] = 16'sd400;
        for (int i = 0; i < 4; i++) sb[i] = '0;
        set_win(exp[0], exp[1], exp[2], exp[3]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        // Behavioural left shift buffer: new word enters at d3, oldest leaves at d0.
        for (int c = 0; c < 6; c++) begin
            if (out_valid && out_ready) begin
                sb[0] = sb[1]; sb[1] = sb[2]; sb[2] = sb[3]; sb[3] = out_data;
                beats++;
            end
            tick();
        end
        total++;
        if (beats != 4) begin
            bad++;
            $display("FAIL roundtrip beats: got %0d want 4", beats);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (sb[i] !== exp[i]) begin
                bad++;
                $display("FAIL roundtrip out_d%0d: got %0d want %0d", i, sb[i], exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [W-1:0] exp [0:3];
        exp[0] = 16'sd10; exp[1] = 16'sd20; exp[2] = 16'sd30; exp[3] = 16'sd40;
        set_win(exp[0], exp[1], exp[2], exp[3]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_data !== 16'sd10 || out_idx !== 2'd0) begin
            bad++;
            $display("FAIL bp beat0: got d=%0d i=%0d want 10 0", out_data, out_idx);
        end
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'sd20 || out_idx !== 2'd1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp stall%0d: got v=%b d=%0d i=%0d r=%b want 1 20 1 0",
                         c, out_valid, out_data, out_idx, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_idx !== 2'(i)) begin
                bad++;
                $display("FAIL bp resume%0d: got v=%b d=%0d i=%0d want 1 %0d %0d",
                         i, out_valid, out_data, out_idx, exp[i], i);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp end: got out_valid=%b want 0 (no duplicate)", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        set_win(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b idle ready: got %b want 1", in_ready);
        end
        tick();
        set_win(16'sd5, 16'sd6, 16'sd7, 16'sd8);
        for (int b = 1; b <= 8; b++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'(b) || out_idx !== 2'((b - 1) % 4) ||
                out_last !== (b == 4 || b == 8) || in_ready !== (b == 4 || b == 8)) begin
                bad++;
                $display("FAIL b2b beat%0d: got v=%b d=%0d i=%0d l=%b r=%b want 1 %0d %0d %b %b",
                         b, out_valid, out_data, out_idx, out_last, in_ready,
                         b, (b - 1) % 4, (b == 4 || b == 8), (b == 4 || b == 8));
            end
            tick();
            if (b == 4) in_valid = 1'b0;
        end
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b end: got v=%b r=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0] exp [0:3];
        exp[0] = 16'h8000; exp[1] = 16'h7FFF; exp[2] = 16'h0000; exp[3] = 16'hFFFF;
        set_win(-16'sd32768, 16'sd32767, 16'sd0, -16'sd1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_data !== exp[i] || out_last !== (i == 3)) begin
                bad++;
                $display("FAIL extremes beat%0d: got d=%h l=%b want d=%h l=%b",
                         i, out_data, out_last, exp[i], (i == 3));
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        set_win(16'sd11, 16'sd22, 16'sd33, 16'sd44);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        // Now past the idx-1 beat; reset lands mid-cycle, away from any edge.
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_idx !== 2'd0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL arst immediate: got v=%b d=%0d i=%0d l=%b r=%b want 0 0 0 0 1",
                     out_valid, out_data, out_idx, out_last, in_ready);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'sd0) begin
                bad++;
                $display("FAIL arst after%0d: got v=%b r=%b d=%0d want 0 1 0",
                         c, out_valid, in_ready, out_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_roundtrip();
        test_backpressure();
        test_back_to_back();
        test_extremes();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
